axilite_master_q: RTL

Queued, parametrised AXI4-Lite master for the FSIC user-side AXI-Lite/AXIS bridge; successor to the single-shot backend-triggered master. Backend requests enter independent write and read command queues with valid/ready flow control. The AXI side issues AW and W concurrently and completes the B channel. Response codes (BRESP/RRESP) are returned to the backend alongside done pulses. Write and read paths run fully independently, each with at most one AXI transaction outstanding.

---
 rtl/axilite_master_q.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axilite_master_q.sv
// -----------------------------------------------------------------------------
// axilite_master_q
//
// Queued AXI4-Lite master. Backend write and read requests are buffered in
// independent circular command queues; each path drives at most one AXI
// transaction at a time. AW and W are issued together. B/R response codes are
// returned to the backend with one-cycle done pulses.
//
// Ports
//   axi_aclk, axi_reset        clock, synchronous active-high reset
//   bk_wstart/bk_wready        write request valid / queue can accept
//   bk_waddr/bk_wdata/bk_wstrb write request payload
//   bk_wdone/bk_wresp          write completion pulse / held BRESP
//   bk_rstart/bk_rready        read request valid / queue can accept
//   bk_raddr                   read request address
//   bk_rdone/bk_rdata/bk_rresp read completion pulse / held RDATA and RRESP
//   axi_aw*, axi_w*, axi_b*    AXI4-Lite write address, data, response
//   axi_ar*, axi_r*            AXI4-Lite read address, data
// -----------------------------------------------------------------------------
module axilite_master_q #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WQ_DEPTH   = 4,
  parameter int RQ_DEPTH   = 4
) (
  input  logic                      axi_aclk,
  input  logic                      axi_reset,
  // backend write
  input  logic                      bk_wstart,
  output logic                      bk_wready,
  input  logic [ADDR_WIDTH-1:0]     bk_waddr,
  input  logic [DATA_WIDTH-1:0]     bk_wdata,
  input  logic [DATA_WIDTH/8-1:0]   bk_wstrb,
  output logic                      bk_wdone,
  output logic [1:0]                bk_wresp,
  // backend read
  input  logic                      bk_rstart,
  output logic                      bk_rready,
  input  logic [ADDR_WIDTH-1:0]     bk_raddr,
  output logic [DATA_WIDTH-1:0]     bk_rdata,
  output logic [1:0]                bk_rresp,
  output logic                      bk_rdone,
  // AXI write address
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  output logic [ADDR_WIDTH-1:0]     axi_awaddr,
  // AXI write data
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  output logic [DATA_WIDTH-1:0]     axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
  // AXI write response
  input  logic                      axi_bvalid,
  output logic                      axi_bready,
  input  logic [1:0]                axi_bresp,
  // AXI read address
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  output logic [ADDR_WIDTH-1:0]     axi_araddr,
  // AXI read data
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  input  logic [DATA_WIDTH-1:0]     axi_rdata,
  input  logic [1:0]                axi_rresp
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int WPW        = $clog2(WQ_DEPTH);
  localparam int WCW        = WPW + 1;
  localparam int RPW        = $clog2(RQ_DEPTH);
  localparam int RCW        = RPW + 1;
  localparam int WE_W       = ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_XFER = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  // ---------------------------------------------------------------------------
  // Write command queue
  // ---------------------------------------------------------------------------
  logic [WE_W-1:0] wq_mem [WQ_DEPTH];
  logic [WPW-1:0]  wq_wr_ptr_q, wq_wr_ptr_d;
  logic [WPW-1:0]  wq_rd_ptr_q, wq_rd_ptr_d;
  logic [WCW-1:0]  wq_cnt_q, wq_cnt_d;
  logic            wq_push, wq_pop;

  // Ready comes from the count alone, so a pop in the same cycle as a full
  // queue does not open a slot for a push.
  assign bk_wready = (wq_cnt_q < WCW'(WQ_DEPTH));
  assign wq_push   = bk_wstart & bk_wready;

  // NOTE: every variable written in an always_comb gets a default first, so
  //       no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wq_wr_ptr_d = wq_wr_ptr_q;
    wq_rd_ptr_d = wq_rd_ptr_q;
    wq_cnt_d    = wq_cnt_q;
    if (wq_push) wq_wr_ptr_d = wq_wr_ptr_q + 1'b1;
    if (wq_pop)  wq_rd_ptr_d = wq_rd_ptr_q + 1'b1;
    case ({wq_push, wq_pop})
      2'b10:   wq_cnt_d = wq_cnt_q + 1'b1;
      2'b01:   wq_cnt_d = wq_cnt_q - 1'b1;
      default: wq_cnt_d = wq_cnt_q;
    endcase
  end

  // NOTE: queue storage has no reset; the count and pointers alone decide
  //       which entries are meaningful, and unreset RAM maps to cheaper cells.
  always_ff @(posedge axi_aclk) begin
    if (wq_push) wq_mem[wq_wr_ptr_q] <= {bk_waddr, bk_wdata, bk_wstrb};
  end

  // ---------------------------------------------------------------------------
  // Read command queue
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] rq_mem [RQ_DEPTH];
  logic [RPW-1:0]        rq_wr_ptr_q, rq_wr_ptr_d;
  logic [RPW-1:0]        rq_rd_ptr_q, rq_rd_ptr_d;
  logic [RCW-1:0]        rq_cnt_q, rq_cnt_d;
  logic                  rq_push, rq_pop;

  assign bk_rready = (rq_cnt_q < RCW'(RQ_DEPTH));
  assign rq_push   = bk_rstart & bk_rready;

  always_comb begin
    rq_wr_ptr_d = rq_wr_ptr_q;
    rq_rd_ptr_d = rq_rd_ptr_q;
    rq_cnt_d    = rq_cnt_q;
    if (rq_push) rq_wr_ptr_d = rq_wr_ptr_q + 1'b1;
    if (rq_pop)  rq_rd_ptr_d = rq_rd_ptr_q + 1'b1;
    case ({rq_push, rq_pop})
      2'b10:   rq_cnt_d = rq_cnt_q + 1'b1;
      2'b01:   rq_cnt_d = rq_cnt_q - 1'b1;
      default: rq_cnt_d = rq_cnt_q;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (rq_push) rq_mem[rq_wr_ptr_q] <= bk_raddr;
  end

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  logic [1:0]            w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [1:0]            bk_wresp_q, bk_wresp_d;
  logic                  bk_wdone_q, bk_wdone_d;

  // Valids come straight from state and done flags, so they and the held
  // payload stay stable until the slave handshakes.
  assign axi_awvalid = (w_state_q == W_XFER) && !aw_done_q;
  assign axi_wvalid  = (w_state_q == W_XFER) && !w_done_q;
  assign axi_bready  = (w_state_q == W_RESP);
  assign axi_awaddr  = axi_awvalid ? w_addr_q : '0;
  assign axi_wdata   = axi_wvalid  ? w_data_q : '0;
  assign axi_wstrb   = axi_wvalid  ? w_strb_q : '0;
  assign bk_wdone    = bk_wdone_q;
  assign bk_wresp    = bk_wresp_q;

  always_comb begin
    w_state_d  = w_state_q;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    bk_wresp_d = bk_wresp_q;
    bk_wdone_d = 1'b0;
    wq_pop     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (|wq_cnt_q) begin
          wq_pop = 1'b1;
          {w_addr_d, w_data_d, w_strb_d} = wq_mem[wq_rd_ptr_q];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_XFER;
        end
      end
      W_XFER: begin
        // Either channel may finish first, or both in the same cycle.
        if (axi_awvalid && axi_awready) aw_done_d = 1'b1;
        if (axi_wvalid && axi_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)      w_state_d = W_RESP;
      end
      W_RESP: begin
        if (axi_bvalid) begin
          bk_wresp_d = axi_bresp;
          bk_wdone_d = 1'b1;
          w_state_d  = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  logic [1:0]            r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [DATA_WIDTH-1:0] bk_rdata_q, bk_rdata_d;
  logic [1:0]            bk_rresp_q, bk_rresp_d;
  logic                  bk_rdone_q, bk_rdone_d;

  assign axi_arvalid = (r_state_q == R_ADDR);
  assign axi_rready  = (r_state_q == R_DATA);
  assign axi_araddr  = axi_arvalid ? r_addr_q : '0;
  assign bk_rdata    = bk_rdata_q;
  assign bk_rresp    = bk_rresp_q;
  assign bk_rdone    = bk_rdone_q;

  always_comb begin
    r_state_d  = r_state_q;
    r_addr_d   = r_addr_q;
    bk_rdata_d = bk_rdata_q;
    bk_rresp_d = bk_rresp_q;
    bk_rdone_d = 1'b0;
    rq_pop     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (|rq_cnt_q) begin
          rq_pop    = 1'b1;
          r_addr_d  = rq_mem[rq_rd_ptr_q];
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (axi_arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (axi_rvalid) begin
          bk_rdata_d = axi_rdata;
          bk_rresp_d = axi_rresp;
          bk_rdone_d = 1'b1;
          r_state_d  = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  //       the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      wq_wr_ptr_q <= '0;
      wq_rd_ptr_q <= '0;
      wq_cnt_q    <= '0;
      rq_wr_ptr_q <= '0;
      rq_rd_ptr_q <= '0;
      rq_cnt_q    <= '0;
      w_state_q   <= W_IDLE;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bk_wresp_q  <= 2'b00;
      bk_wdone_q  <= 1'b0;
      r_state_q   <= R_IDLE;
      r_addr_q    <= '0;
      bk_rdata_q  <= '0;
      bk_rresp_q  <= 2'b00;
      bk_rdone_q  <= 1'b0;
    end else begin
      wq_wr_ptr_q <= wq_wr_ptr_d;
      wq_rd_ptr_q <= wq_rd_ptr_d;
      wq_cnt_q    <= wq_cnt_d;
      rq_wr_ptr_q <= rq_wr_ptr_d;
      rq_rd_ptr_q <= rq_rd_ptr_d;
      rq_cnt_q    <= rq_cnt_d;
      w_state_q   <= w_state_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bk_wresp_q  <= bk_wresp_d;
      bk_wdone_q  <= bk_wdone_d;
      r_state_q   <= r_state_d;
      r_addr_q    <= r_addr_d;
      bk_rdata_q  <= bk_rdata_d;
      bk_rresp_q  <= bk_rresp_d;
      bk_rdone_q  <= bk_rdone_d;
    end
  end

endmodule
